// File: rtl/pmem_arb_pkg.sv
// Shared widths, types and helpers for the cache-to-physical-memory arbiter.
package pmem_arb_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned LINE_W      = 256;
  localparam int unsigned BEAT_W      = 64;
  localparam int unsigned BEATS       = LINE_W / BEAT_W;
  localparam int unsigned CNT_W       = $clog2(BEATS);
  localparam int unsigned OFFSET_BITS = $clog2(LINE_W / 8);

  typedef logic [BEAT_W-1:0]             beat_t;
  typedef logic [BEATS-1:0][BEAT_W-1:0]  line_t;
  typedef logic [CNT_W-1:0]              cnt_t;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} arb_req_t;

  // Clear the byte-offset bits so every burst starts on a line boundary.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'(0)};
  endfunction

endpackage

// File: rtl/pmem_burst_adaptor.sv
// Beat counter plus the shared line register used to assemble read beats
// and to serve write beats one slice at a time.
module pmem_burst_adaptor
  import pmem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clear,
  input  logic  load,
  input  line_t wline,
  input  logic  beat_en,
  input  logic  is_read,
  input  beat_t rbeat,
  output beat_t wbeat,
  output line_t line_c,
  output logic  last_c
);

  cnt_t  cnt_q;
  cnt_t  cnt_nxt;
  line_t line_q;

  assign cnt_nxt = cnt_q + CNT_W'(1);
  assign last_c  = (cnt_q == CNT_W'(BEATS - 1));

  // Line with the beat currently on the bus dropped into its slot.
  always_comb begin
    line_c        = line_q;
    line_c[cnt_q] = rbeat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      line_q <= '0;
      wbeat  <= '0;
    end else begin
      if (clear) begin
        cnt_q <= '0;
      end else if (beat_en) begin
        cnt_q <= cnt_nxt;
      end
      if (load) begin
        line_q <= wline;
        wbeat  <= wline[0];
      end else if (beat_en) begin
        if (is_read) begin
          line_q <= line_c;
        end else begin
          // Preload the following slice so the write beat is a flop output.
          wbeat <= line_q[cnt_nxt];
        end
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates I-cache and D-cache line requests onto one 4-beat pmem port.
// Define PMEM_ARB_RR_EN for round-robin on conflicts; otherwise D beats I.
module pmem_arbiter
  import pmem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_read,
  input  logic [ADDR_W-1:0] imem_address,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_nxt;
  arb_req_t   grant_q, grant_nxt;
  logic       start, wr_load, pick_d, d_req, i_req, beat_en, last_c;
  line_t      line_c;

  assign d_req   = dmem_read | dmem_write;
  assign i_req   = imem_read;
  assign beat_en = pmem_resp && ((state_q == READ) || (state_q == WRITE));

`ifdef PMEM_ARB_RR_EN
  arb_req_t last_q;

  // On a conflict, favour whichever requester was not granted last.
  assign pick_d = d_req && (!i_req || (last_q == REQ_I));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= REQ_I;
    end else if (start) begin
      last_q <= grant_nxt;
    end
  end
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    start     = 1'b0;
    wr_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_d) begin
          start     = 1'b1;
          wr_load   = dmem_write;
          grant_nxt = REQ_D;
          state_nxt = dmem_write ? WRITE : READ;
        end else if (i_req) begin
          start     = 1'b1;
          grant_nxt = REQ_I;
          state_nxt = READ;
        end
      end
      READ, WRITE: begin
        if (beat_en && last_c) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= REQ_D;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      imem_resp    <= 1'b0;
      dmem_resp    <= 1'b0;
      imem_rdata   <= '0;
      dmem_rdata   <= '0;
    end else begin
      state_q    <= state_nxt;
      grant_q    <= grant_nxt;
      pmem_read  <= (state_nxt == READ);
      pmem_write <= (state_nxt == WRITE);
      imem_resp  <= (state_nxt == DONE) && (grant_q == REQ_I);
      dmem_resp  <= (state_nxt == DONE) && (grant_q == REQ_D);
      if (start) begin
        pmem_address <= line_align(pick_d ? dmem_address : imem_address);
      end
      // Read data only changes when that requester's own read completes.
      if ((state_q == READ) && beat_en && last_c) begin
        if (grant_q == REQ_D) begin
          dmem_rdata <= line_c;
        end else begin
          imem_rdata <= line_c;
        end
      end
    end
  end

  pmem_burst_adaptor u_burst (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q == IDLE),
    .load    (wr_load),
    .wline   (dmem_wdata),
    .beat_en (beat_en),
    .is_read (state_q == READ),
    .rbeat   (pmem_rdata),
    .wbeat   (pmem_wdata),
    .line_c  (line_c),
    .last_c  (last_c)
  );

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter; expectations follow PMEM_ARB_RR_EN when defined.
module tb_pmem_arbiter;
  import pmem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_read;
  logic [ADDR_W-1:0] imem_address;
  logic [LINE_W-1:0] imem_rdata;
  logic              imem_resp;
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [LINE_W-1:0] dmem_wdata;
  logic [LINE_W-1:0] dmem_rdata;
  logic              dmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [BEAT_W-1:0] pmem_wdata;
  logic [BEAT_W-1:0] pmem_rdata;
  logic              pmem_resp;

  int vectors     = 0;
  int miscompares = 0;

  pmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plays the memory side of one burst. Cycle 0 is the caller's current cycle;
  // returns the cycle number in which a *_resp was seen.
  task automatic serve(input bit exp_write, input bit exp_d, input logic [ADDR_W-1:0] exp_addr,
                       input line_t rd_line, input line_t wr_line,
                       input int stall_beat, input int stall_len, output int resp_cycle);
    int beat, stalls, cyc;
    bit got;
    beat = 0; stalls = 0; cyc = 0; got = 1'b0; resp_cycle = -1;
    while (!got && cyc < 40) begin
      step;
      cyc++;
      if (imem_resp === 1'b1 || dmem_resp === 1'b1) begin
        got        = 1'b1;
        resp_cycle = cyc;
        pmem_resp  = 1'b0;
        chk("resp_d", dmem_resp, exp_d);
        chk("resp_i", imem_resp, !exp_d);
        chk("done_pmem_read", pmem_read, 1'b0);
        chk("done_pmem_write", pmem_write, 1'b0);
        chk("beats_used", beat, BEATS);
      end else begin
        chk("pmem_read", pmem_read, !exp_write);
        chk("pmem_write", pmem_write, exp_write);
        chk("pmem_address", pmem_address, exp_addr);
        if (exp_write && beat < BEATS) chk("pmem_wdata", pmem_wdata, wr_line[beat]);
        if (beat >= BEATS) begin
          pmem_resp = 1'b0;
        end else if (beat == stall_beat && stalls < stall_len) begin
          pmem_resp = 1'b0;
          stalls++;
        end else begin
          pmem_resp  = 1'b1;
          pmem_rdata = rd_line[beat];
          beat++;
        end
      end
    end
    chk("resp_seen", got, 1'b1);
  endtask

  initial begin
    line_t li, li2, li3, ld1, ld3, ld4, ld5, lw, lw2;
    int    rc;
    bit    first_d;

    li  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    li2 = {64'ha203_a203_a203_a203, 64'ha202_a202_a202_a202, 64'ha201_a201_a201_a201, 64'ha200_a200_a200_a200};
    li3 = {64'ha303_0000_0000_a303, 64'ha302_0000_0000_a302, 64'ha301_0000_0000_a301, 64'ha300_0000_0000_a300};
    ld1 = {64'hd103_d103_d103_d103, 64'hd102_d102_d102_d102, 64'hd101_d101_d101_d101, 64'hd100_d100_d100_d100};
    ld3 = {64'hd303_d303_d303_d303, 64'hd302_d302_d302_d302, 64'hd301_d301_d301_d301, 64'hd300_d300_d300_d300};
    ld4 = {64'hd403_d403_d403_d403, 64'hd402_d402_d402_d402, 64'hd401_d401_d401_d401, 64'hd400_d400_d400_d400};
    ld5 = {64'hd503_0000_ffff_d503, 64'hd502_0000_ffff_d502, 64'hd501_0000_ffff_d501, 64'hd500_0000_ffff_d500};
    lw  = {64'hbbbb_0003_cafe_0003, 64'hbbbb_0002_cafe_0002, 64'hbbbb_0001_cafe_0001, 64'hbbbb_0000_cafe_0000};
    lw2 = {64'h7777_0003_1234_5678, 64'h6666_0002_1234_5678, 64'h5555_0001_1234_5678, 64'h4444_0000_1234_5678};

    rst = 1'b0;
    imem_read = 1'b0; imem_address = '0;
    dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0; dmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 32'h0);
    chk("rst_pmem_wdata", pmem_wdata, 64'h0);
    chk("rst_imem_resp", imem_resp, 1'b0);
    chk("rst_dmem_resp", dmem_resp, 1'b0);
    chk("rst_imem_rdata", imem_rdata, 256'h0);
    chk("rst_dmem_rdata", dmem_rdata, 256'h0);
    rst = 1'b1;
    step;

    // First conflict: D wins in both builds, then I.
    dmem_read = 1'b1; dmem_address = 32'h1000_0048;
    imem_read = 1'b1; imem_address = 32'h0000_0104;
    serve(1'b0, 1'b1, 32'h1000_0040, ld1, '0, 99, 0, rc);
    chk("c1_d_latency", rc, 5);
    chk("c1_d_rdata", dmem_rdata, ld1);
    dmem_read = 1'b0;
    step;
    chk("c1_idle_pmem_read", pmem_read, 1'b0);
    chk("c1_idle_dmem_resp", dmem_resp, 1'b0);
    serve(1'b0, 1'b0, 32'h0000_0100, li2, '0, 99, 0, rc);
    chk("c1_i_latency", rc, 5);
    chk("c1_i_rdata", imem_rdata, li2);
    imem_read = 1'b0;
    step;

    // I read of 0x64 with back-to-back beats.
    imem_read = 1'b1; imem_address = 32'h0000_0064;
    serve(1'b0, 1'b0, 32'h0000_0060, li, '0, 99, 0, rc);
    chk("i_latency", rc, 5);
    chk("i_rdata", imem_rdata, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
    chk("i_dmem_rdata_kept", dmem_rdata, ld1);
    imem_read = 1'b0;
    step;
    chk("i_resp_one_cycle", imem_resp, 1'b0);

    // D writeback of 0x8000_0020.
    dmem_write = 1'b1; dmem_address = 32'h8000_0020; dmem_wdata = lw;
    serve(1'b1, 1'b1, 32'h8000_0020, '0, lw, 99, 0, rc);
    chk("w_latency", rc, 5);
    dmem_write = 1'b0;
    step;
    chk("w_resp_one_cycle", dmem_resp, 1'b0);

    // Writeback with a 3-cycle stall before beat 2.
    dmem_write = 1'b1; dmem_address = 32'h8000_1234; dmem_wdata = lw2;
    serve(1'b1, 1'b1, 32'h8000_1220, '0, lw2, 2, 3, rc);
    chk("stall_latency", rc, 8);
    dmem_write = 1'b0;
    step;

    // Back-to-back D reads.
    dmem_read = 1'b1; dmem_address = 32'h2000_0000;
    serve(1'b0, 1'b1, 32'h2000_0000, ld3, '0, 99, 0, rc);
    chk("b2b_1_latency", rc, 5);
    chk("b2b_1_rdata", dmem_rdata, ld3);
    dmem_read = 1'b0;
    step;
    chk("b2b_gap_pmem_read", pmem_read, 1'b0);
    chk("b2b_gap_dmem_resp", dmem_resp, 1'b0);
    dmem_read = 1'b1; dmem_address = 32'h2000_0020;
    serve(1'b0, 1'b1, 32'h2000_0020, ld4, '0, 99, 0, rc);
    chk("b2b_2_latency", rc, 5);
    chk("b2b_2_rdata", dmem_rdata, ld4);
    dmem_read = 1'b0;
    step;
    chk("b2b_2_resp_one_cycle", dmem_resp, 1'b0);

    // Second conflict, D served last.
`ifdef PMEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    dmem_read = 1'b1; dmem_address = 32'h3000_0010;
    imem_read = 1'b1; imem_address = 32'h0000_0200;
    if (first_d) begin
      serve(1'b0, 1'b1, 32'h3000_0000, ld5, '0, 99, 0, rc);
      chk("c2_first_rdata", dmem_rdata, ld5);
      dmem_read = 1'b0;
      step;
      serve(1'b0, 1'b0, 32'h0000_0200, li3, '0, 99, 0, rc);
      chk("c2_second_rdata", imem_rdata, li3);
      imem_read = 1'b0;
    end else begin
      serve(1'b0, 1'b0, 32'h0000_0200, li3, '0, 99, 0, rc);
      chk("c2_first_rdata", imem_rdata, li3);
      imem_read = 1'b0;
      step;
      serve(1'b0, 1'b1, 32'h3000_0000, ld5, '0, 99, 0, rc);
      chk("c2_second_rdata", dmem_rdata, ld5);
      dmem_read = 1'b0;
    end
    chk("c2_second_latency", rc, 5);
    step;

    // Reset asserted while beat 2 of an I read is on the bus.
    imem_read = 1'b1; imem_address = 32'h0000_0400;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("rst_burst_pmem_read", pmem_read, 1'b1);
      pmem_resp = 1'b1; pmem_rdata = li[k];
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_pmem_read", pmem_read, 1'b0);
    chk("midrst_pmem_address", pmem_address, 32'h0);
    chk("midrst_imem_rdata", imem_rdata, 256'h0);
    chk("midrst_dmem_rdata", dmem_rdata, 256'h0);
    imem_read = 1'b0; pmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      chk("midrst_no_imem_resp", imem_resp, 1'b0);
      chk("midrst_no_dmem_resp", dmem_resp, 1'b0);
    end
    rst = 1'b1;
    step;
    chk("post_rst_idle_resp", imem_resp, 1'b0);

    // Fresh I read after reset release.
    imem_read = 1'b1; imem_address = 32'h0000_0064;
    serve(1'b0, 1'b0, 32'h0000_0060, li, '0, 99, 0, rc);
    chk("post_rst_latency", rc, 5);
    chk("post_rst_rdata", imem_rdata, li);
    imem_read = 1'b0;
    step;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
